// File: rtl/fetch_sequencer.sv
// Fetch-side sequencer: owns the PC, arbitrates the instruction-memory port
// between the host loader and fetch, and steps through IDLE/RUN/DRAIN/HALT.
module fetch_sequencer #(
  parameter int PC_WIDTH     = 8,
  parameter int INSTR_WIDTH  = 32,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   host_wr_en,
  input  logic [PC_WIDTH-1:0]    host_wr_addr,
  input  logic [INSTR_WIDTH-1:0] host_wr_data,
  input  logic                   host_start,
  input  logic [PC_WIDTH-1:0]    host_start_pc,
  output logic                   host_err,
  input  logic                   hz_stall,
  input  logic                   br_taken,
  input  logic [PC_WIDTH-1:0]    br_target,
  input  logic                   halt_detect,
  output logic                   imem_we,
  output logic [PC_WIDTH-1:0]    imem_addr,
  output logic [INSTR_WIDTH-1:0] imem_wdata,
  output logic [PC_WIDTH-1:0]    pc,
  output logic                   ifid_en,
  output logic                   ifid_flush,
  output logic                   idex_flush,
  output logic                   busy,
  output logic                   halted,
  output logic [CNT_WIDTH-1:0]   fetch_cnt
);

  localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HALT} state_t;

  state_t                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]          drain_q, drain_d;
  logic                   we_q, we_d;
  logic [PC_WIDTH-1:0]    waddr_q, waddr_d;
  logic [INSTR_WIDTH-1:0] wdata_q, wdata_d;
  logic                   err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      drain_q <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    drain_d    = drain_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    err_d      = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b1;
    idex_flush = 1'b0;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (host_wr_en) begin
          we_d    = 1'b1;
          waddr_d = host_wr_addr;
          wdata_d = host_wr_data;
        end
        // A start colliding with a write loses; the write still lands.
        if (host_start) begin
          if (host_wr_en) err_d = 1'b1;
          else begin
            pc_d    = host_start_pc;
            cnt_d   = '0;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        err_d      = host_wr_en | host_start;
        ifid_flush = 1'b0;
        if (br_taken) begin
          pc_d       = br_target;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          cnt_d      = cnt_q + 1'b1;
        end else if (hz_stall) begin
          idex_flush = 1'b1;
        end else if (halt_detect) begin
          ifid_flush = 1'b1;
          drain_d    = DW'(DRAIN_CYCLES);
          state_d    = S_DRAIN;
        end else begin
          pc_d    = pc_q + 1'b1;
          ifid_en = 1'b1;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        err_d = host_wr_en | host_start;
        if (drain_q <= DW'(1)) state_d = S_HALT;
        else drain_d = drain_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign halted     = (state_q == S_HALT);
  assign imem_we    = we_q;
  assign imem_addr  = busy ? pc_q : waddr_q;
  assign imem_wdata = wdata_q;
  assign pc         = pc_q;
  assign host_err   = err_q;
  assign fetch_cnt  = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a cycle-level reference model queues
// expected outputs; an independent monitor compares them against the DUT.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        host_wr_en, host_start, hz_stall, br_taken, halt_detect;
  logic [7:0]  host_wr_addr, host_start_pc, br_target;
  logic [31:0] host_wr_data;
  logic        host_err, imem_we, ifid_en, ifid_flush, idex_flush, busy, halted;
  logic [7:0]  imem_addr, pc;
  logic [31:0] imem_wdata;
  logic [15:0] fetch_cnt;

  fetch_sequencer #(.PC_WIDTH(8), .INSTR_WIDTH(32), .DRAIN_CYCLES(3), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .host_start(host_start), .host_start_pc(host_start_pc), .host_err(host_err),
    .hz_stall(hz_stall), .br_taken(br_taken), .br_target(br_target),
    .halt_detect(halt_detect), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .pc(pc), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .busy(busy), .halted(halted), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] cnt;
    logic        busy, halted, en, ff, xf, we, err;
    logic [7:0]  addr;
    logic [31:0] wdata;
    bit          chk_en, chk_addr, chk_wdata;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: plain spec-level state, updated once per stimulus cycle.
  localparam int MI = 0, MR = 1, MD = 2, MH = 3;
  int          m_state;
  logic [7:0]  m_pc, m_waddr;
  logic [15:0] m_cnt;
  int          m_drain;
  logic        m_we, m_err, m_rstd;
  logic [31:0] m_wdata;

  task automatic model_reset();
    m_state = MI; m_pc = 0; m_cnt = 0; m_drain = 0;
    m_we = 0; m_err = 0; m_waddr = 0; m_wdata = 0; m_rstd = 1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic step(input bit r, input bit wr, input logic [7:0] wa, input logic [31:0] wd,
                      input bit st, input logic [7:0] sp, input bit stl, input bit br,
                      input logic [7:0] bt, input bit hlt);
    exp_t e;
    bit   run, ld;
    @(negedge clk);
    assert (!(m_state == MD && (br || stl)));
    rst = r; host_wr_en = wr; host_wr_addr = wa; host_wr_data = wd;
    host_start = st; host_start_pc = sp; hz_stall = stl; br_taken = br;
    br_target = bt; halt_detect = hlt;
    run = (m_state == MR);
    ld  = (m_state == MI) || (m_state == MH);
    e.pc = m_pc; e.cnt = m_cnt; e.we = m_we; e.err = m_err;
    e.busy = (m_state == MR) || (m_state == MD);
    e.halted = (m_state == MH);
    e.en = run && !br && !stl && !hlt;
    e.ff = !run || br || (!stl && hlt);
    e.xf = run && (br || stl);
    e.chk_en = !(run && (br || (!stl && hlt)));
    e.addr = e.busy ? m_pc : m_waddr;
    e.wdata = m_wdata;
    e.chk_addr = e.busy || m_we || m_rstd;
    e.chk_wdata = ld && (m_we || m_rstd);
    exp_q.push_back(e);
    if (r) model_reset();
    else begin
      m_we = 0; m_err = 0;
      if (ld) begin
        if (wr) begin m_we = 1; m_waddr = wa; m_wdata = wd; m_rstd = 0; end
        if (st && wr) m_err = 1;
        else if (st) begin m_pc = sp; m_cnt = 0; m_state = MR; end
      end else if (run) begin
        m_err = wr || st;
        if (br) begin m_pc = bt; m_cnt = m_cnt + 16'd1; end
        else if (stl) ;
        else if (hlt) begin m_drain = 3; m_state = MD; end
        else begin m_pc = m_pc + 8'd1; m_cnt = m_cnt + 16'd1; end
      end else begin
        m_err = wr || st;
        if (m_drain <= 1) m_state = MH;
        else m_drain--;
      end
    end
  endtask

  task automatic idle();                       step(0,0,0,0,0,0,0,0,0,0); endtask
  task automatic wr_word(input logic [7:0] a, input logic [31:0] d); step(0,1,a,d,0,0,0,0,0,0); endtask
  task automatic start(input logic [7:0] p);   step(0,0,0,0,1,p,0,0,0,0); endtask
  task automatic stall();                      step(0,0,0,0,0,0,1,0,0,0); endtask
  task automatic branch(input logic [7:0] t);  step(0,0,0,0,0,0,0,1,t,0); endtask
  task automatic halt();                       step(0,0,0,0,0,0,0,0,0,1); endtask

  // Monitor: the DUT presents a full output set every cycle; compare mid-low phase.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc", pc, e.pc);
        chk("fetch_cnt", fetch_cnt, e.cnt);
        chk("busy", busy, e.busy);
        chk("halted", halted, e.halted);
        chk("ifid_flush", ifid_flush, e.ff);
        chk("idex_flush", idex_flush, e.xf);
        chk("imem_we", imem_we, e.we);
        chk("host_err", host_err, e.err);
        if (e.chk_en)    chk("ifid_en", ifid_en, e.en);
        if (e.chk_addr)  chk("imem_addr", imem_addr, e.addr);
        if (e.chk_wdata) chk("imem_wdata", imem_wdata, e.wdata);
      end
    end
  end

  initial begin
    rst = 1; host_wr_en = 0; host_wr_addr = 0; host_wr_data = 0; host_start = 0;
    host_start_pc = 0; hz_stall = 0; br_taken = 0; br_target = 0; halt_detect = 0;
    model_reset();
    repeat (2) @(posedge clk);
    // reset values, then a loader write with one-cycle latency
    wr_word(8'h05, 32'hDEADBEEF);
    idle();
    // start near the top of memory to cover PC wrap
    start(8'hFE);
    repeat (4) idle();
    // stalls at pc 0x10
    branch(8'h10); stall(); stall(); idle(); idle();
    // branch beats same-cycle stall and halt
    step(0,0,0,0,0,0,1,1,8'h40,1); idle();
    // halt at 0x20, drain, restart from HALT
    branch(8'h20); halt(); repeat (4) idle();
    wr_word(8'h33, 32'h12345678);
    start(8'h00); idle(); idle();
    // host requests rejected in RUN; reset during DRAIN
    wr_word(8'h07, 32'hCAFEF00D); idle();
    step(0,0,0,0,1,8'h55,0,0,0,0); idle();
    halt(); idle();
    step(1,0,0,0,0,0,0,0,0,0); idle();
    // start and write colliding in IDLE
    step(0,1,8'h09,32'hA5A5A5A5,1,8'h80,0,0,0,0); idle();
    // randomized phase
    for (int i = 0; i < 600; i++) begin
      bit r, wr, st, stl, br, hlt;
      r   = ($urandom_range(0, 99) < 1);
      wr  = ($urandom_range(0, 99) < 20);
      st  = ($urandom_range(0, 99) < ((m_state == MR) ? 3 : 30));
      stl = ($urandom_range(0, 99) < 15);
      br  = ($urandom_range(0, 99) < 10);
      hlt = ($urandom_range(0, 99) < 4);
      if (m_state == MD) begin stl = 0; br = 0; end
      step(r, wr, 8'($urandom), $urandom, st, 8'($urandom), stl, br, 8'($urandom), hlt);
    end
    idle();
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_queue: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Controls the instruction fetch side of the 5-stage pipeline (IF/ID/EX/MEM/WB). It owns the PC and decides whether it increments, holds, or loads a branch target. It shares the single instruction-memory port between the host program loader and the fetch stage. It also sequences the pipeline through start, stall, branch flush, halt-drain and halted states.

Parameters:
PC_WIDTH, 8, PC and instruction-memory address width (memory depth 2^PC_WIDTH = 256).
INSTR_WIDTH, 32, instruction word width.
DRAIN_CYCLES, 3, cycles to wait after HALT decode for the EX/MEM/WB stages to empty.
CNT_WIDTH, 16, width of the fetched-instruction counter.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
host_wr_en  in  1  host request to write one instruction word.
host_wr_addr  in  PC_WIDTH  host write address.
host_wr_data  in  INSTR_WIDTH  host write data.
host_start  in  1  one-cycle pulse: begin execution at host_start_pc.
host_start_pc  in  PC_WIDTH  start address.
host_err  out  1  one-cycle pulse: host write or start rejected.
hz_stall  in  1  load-use stall request from the hazard unit.
br_taken  in  1  branch resolved taken in EX.
br_target  in  PC_WIDTH  branch target address.
halt_detect  in  1  HALT opcode decoded in ID.
imem_we  out  1  instruction-memory write enable.
imem_addr  out  PC_WIDTH  instruction-memory address.
imem_wdata  out  INSTR_WIDTH  instruction-memory write data.
pc  out  PC_WIDTH  current fetch PC.
ifid_en  out  1  IF/ID pipeline register load enable.
ifid_flush  out  1  IF/ID register loads a bubble.
idex_flush  out  1  ID/EX register loads a bubble.
busy  out  1  high in RUN or DRAIN.
halted  out  1  high in HALT.
fetch_cnt  out  CNT_WIDTH  number of instructions fetched since the last start.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. All state is updated on the rising edge of clk.
- States: IDLE, RUN, DRAIN, HALT.
- Reset values: state=IDLE, pc=0, fetch_cnt=0, imem_we=0, imem_addr=0, imem_wdata=0, host_err=0, ifid_en=0, ifid_flush=1, idex_flush=0, busy=0, halted=0. Any pending registered write is dropped.
- Reset mid-operation: returns to the reset values at the next edge from any state.
- IDLE and HALT (loader owns the memory port):
  - ifid_en=0, ifid_flush=1.
  - host_wr_en is registered and presented on the next cycle: imem_we=1, imem_addr=host_wr_addr, imem_wdata=host_wr_data (1-cycle latency).
  - host_start with no host_wr_en: pc<=host_start_pc, fetch_cnt<=0, next state RUN.
  - host_start and host_wr_en in the same cycle: the write is performed, the start is ignored, host_err pulses.
- RUN (fetch owns the port):
  - imem_addr=pc, imem_we=0, busy=1.
  - Priority per cycle, highest first:
    1. br_taken: pc<=br_target, ifid_flush=1, idex_flush=1, fetch_cnt+1. Overrides a same-cycle hz_stall and halt_detect (those belong to the wrong path).
    2. hz_stall: pc holds, ifid_en=0, idex_flush=1, fetch_cnt holds.
    3. halt_detect: pc holds, ifid_flush=1, drain counter<=DRAIN_CYCLES, next state DRAIN.
    4. Otherwise: pc<=pc+1 modulo 2^PC_WIDTH (255 wraps to 0, no error), ifid_en=1, fetch_cnt+1.
  - host_wr_en or host_start: ignored, host_err pulses.
- DRAIN:
  - pc holds, ifid_en=0, ifid_flush=1, busy=1.
  - Counter decrements each cycle; at 1, next state HALT.
  - br_taken and hz_stall are ignored; the verification bench asserts they never occur here.
  - Host requests are rejected with host_err.
- HALT: halted=1, busy=0. Behaves as IDLE: reload and restart are allowed.
- fetch_cnt wraps modulo 2^CNT_WIDTH.

Test Plan:
- Reset, write 0xDEADBEEF to address 5 from IDLE -> next cycle imem_we=1, imem_addr=5, imem_wdata=0xDEADBEEF; pc=0, ifid_flush=1.
- host_start with pc 0xFE, no hazards for 3 cycles -> pc sequence FE, FF, 00, 01; fetch_cnt=3; busy=1.
- In RUN at pc=0x10, hz_stall for 2 cycles -> pc holds 0x10, ifid_en=0, idex_flush=1; resumes at 0x11 afterwards.
- br_taken with br_target 0x40 in the same cycle as hz_stall and halt_detect -> next pc=0x40, ifid_flush=idex_flush=1, state stays RUN.
- halt_detect at pc=0x20 -> DRAIN for 3 cycles with pc=0x20, then halted=1, busy=0; host_start at pc 0 then restarts with fetch_cnt=0.
- host_wr_en during RUN -> host_err pulses 1 cycle, imem_we stays 0; rst asserted during DRAIN -> next edge IDLE with all reset values.
